// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN convolution layers: FSM state encoding
// and the exact accumulator width needed for a K*K multiply-accumulate.
package cnn_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_F = 3'd1;
  localparam logic [2:0] ST_LOAD_I = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD_F = ST_LOAD_F,
    LOAD_I = ST_LOAD_I,
    DRAIN  = ST_DRAIN,
    DONE   = ST_DONE
  } cnn_state_t;

  // Unsigned pixels gain one bit when zero-extended into the signed multiply.
  function automatic int acc_width(input int data_w, input int coef_w,
                                   input int k, input int signed_px);
    return data_w + coef_w + ((signed_px != 0) ? 0 : 1) + $clog2(k * k);
  endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// Delay line of K-1 image rows plus K pixels; exposes the K x K window ending at
// the most recently pushed pixel, flattened as index row*K+col (row 0 = oldest).
module cnn_line_buffer #(
  parameter int IMG_W  = 6,
  parameter int K      = 3,
  parameter int DATA_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        data,
  output logic [K*K*DATA_W-1:0]    window
);

  localparam int LEN = (K - 1) * IMG_W + K;

  logic [DATA_W-1:0] taps [LEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LEN; i++) taps[i] <= '0;
    end else if (push) begin
      taps[0] <= data;
      for (int i = 1; i < LEN; i++) taps[i] <= taps[i-1];
    end
  end

  // taps[0] is the newest pixel, i.e. the bottom-right corner of the window.
  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign window[(r*K+c)*DATA_W +: DATA_W] = taps[(K-1-r)*IMG_W + (K-1-c)];
    end
  end

endmodule

// File: rtl/cnn_conv_layer_p.sv
// Single valid-mode convolution layer: serial filter load, row-major pixel stream,
// two-stage MAC pipeline (products, then sum/ReLU), done pulse after the drain.
module cnn_conv_layer_p
  import cnn_pkg::*;
#(
  parameter int IMG_W       = 6,
  parameter int IMG_H       = 6,
  parameter int K           = 3,
  parameter int DATA_W      = 4,
  parameter int DATA_SIGNED = 0,
  parameter int COEF_W      = 4,
  localparam int ACC_W      = acc_width(DATA_W, COEF_W, K, DATA_SIGNED)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              relu_en,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              coef_valid,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  output logic              busy,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_valid,
  output logic              done
);

  localparam int NT   = K * K;
  localparam int PR_W = DATA_W + 1 + COEF_W;
  localparam int FW   = $clog2(NT);
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);

  cnn_state_t state, state_nxt;

  logic [FW-1:0]     coef_idx;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              drain_cnt;
  logic              relu_q;
  logic [COEF_W-1:0] coef [NT];

  logic              coef_acc, last_coef, pix_acc, last_pix;
  logic [NT*DATA_W-1:0] win;

  logic              tag, v1;
  logic signed [PR_W-1:0]  prod_d [NT];
  logic signed [PR_W-1:0]  prod_q [NT];
  logic signed [ACC_W-1:0] sum;

  assign coef_acc  = (state == LOAD_F) && coef_valid;
  assign last_coef = coef_acc && (coef_idx == FW'(NT - 1));
  assign pix_acc   = (state == LOAD_I) && pix_valid;
  assign last_pix  = pix_acc && (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = LOAD_F;
      LOAD_F:  if (last_coef) state_nxt = LOAD_I;
      LOAD_I:  if (last_pix)  state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_idx  <= '0;
      col       <= '0;
      row       <= '0;
      drain_cnt <= 1'b0;
      relu_q    <= 1'b0;
      for (int i = 0; i < NT; i++) coef[i] <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        relu_q   <= relu_en;
        coef_idx <= '0;
        col      <= '0;
        row      <= '0;
      end
      if (coef_acc) begin
        coef[coef_idx] <= coef_data;
        coef_idx       <= coef_idx + FW'(1);
      end
      if (pix_acc) begin
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  cnn_line_buffer #(
    .IMG_W  (IMG_W),
    .K      (K),
    .DATA_W (DATA_W)
  ) u_line_buffer (
    .clk    (clk),
    .rst    (rst),
    .push   (pix_acc),
    .data   (pix_data),
    .window (win)
  );

  // One extra pixel bit covers both modes: zero-extend unsigned, sign-extend signed.
  for (genvar i = 0; i < NT; i++) begin : g_mul
    logic [DATA_W-1:0]   pw;
    logic signed [DATA_W:0] pe;
    assign pw        = win[i*DATA_W +: DATA_W];
    assign pe        = {(DATA_SIGNED != 0) && pw[DATA_W-1], pw};
    assign prod_d[i] = PR_W'(pe) * PR_W'($signed(coef[i]));
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NT; i++) sum = sum + ACC_W'(prod_q[i]);
  end

  // The tag marks windows fully inside the image; it rides alongside the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag       <= 1'b0;
      v1        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < NT; i++) prod_q[i] <= '0;
    end else begin
      tag       <= pix_acc && (row >= RW'(K - 1)) && (col >= CW'(K - 1));
      v1        <= tag;
      out_valid <= v1;
      for (int i = 0; i < NT; i++) prod_q[i] <= prod_d[i];
      if (v1) out_data <= (relu_q && sum[ACC_W-1]) ? '0 : sum;
    end
  end

endmodule

// File: tb/tb_cnn_conv_layer_p.sv
// Directed bench: expected results are queued per run, a monitor per DUT pops
// and compares on every out_valid.
`timescale 1ns/1ps
module tb_cnn_conv_layer_p;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start0 = 0, relu0 = 0, cv0 = 0, pv0 = 0;
  logic [3:0]  cd0 = 0, pd0 = 0;
  logic        busy0, ov0, done0;
  logic [12:0] od0;

  logic        start1 = 0, relu1 = 0, cv1 = 0, pv1 = 0;
  logic [3:0]  cd1 = 0, pd1 = 0;
  logic        busy1, ov1, done1;
  logic [11:0] od1;

  cnn_conv_layer_p #(
    .IMG_W(6), .IMG_H(6), .K(3), .DATA_W(4), .DATA_SIGNED(0), .COEF_W(4)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start0), .relu_en(relu0),
    .coef_data(cd0), .coef_valid(cv0), .pix_data(pd0), .pix_valid(pv0),
    .busy(busy0), .out_data(od0), .out_valid(ov0), .done(done0)
  );

  cnn_conv_layer_p #(
    .IMG_W(4), .IMG_H(4), .K(3), .DATA_W(4), .DATA_SIGNED(1), .COEF_W(4)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start1), .relu_en(relu1),
    .coef_data(cd1), .coef_valid(cv1), .pix_data(pd1), .pix_valid(pv1),
    .busy(busy1), .out_data(od1), .out_valid(ov1), .done(done1)
  );

  int n_cmp = 0, n_err = 0;
  int ov_cnt0 = 0, ov_cnt1 = 0;
  int q0[$];
  int q1[$];
  int coef_tab[9];
  int pix_tab[36];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon0
    int e;
    if (ov0) begin
      ov_cnt0++;
      if (q0.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_result0: got %0d, expected no result", $signed(od0));
      end else begin
        e = q0.pop_front();
        check("result0", int'($signed(od0)), e);
      end
    end
  end

  always @(negedge clk) begin : mon1
    int e;
    if (ov1) begin
      ov_cnt1++;
      if (q1.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_result1: got %0d, expected no result", $signed(od1));
      end else begin
        e = q1.pop_front();
        check("result1", int'($signed(od1)), e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // cmode: 0 all ones, 1 identity, 2 all -8.  pmode: 0 all 15, 1 (row*6+col) mod 16.
  task automatic set_tabs(input int cmode, input int pmode);
    for (int i = 0; i < 9; i++)
      coef_tab[i] = (cmode == 0) ? 1 : (cmode == 2) ? -8 : ((i == 4) ? 1 : 0);
    for (int i = 0; i < 36; i++)
      pix_tab[i] = (pmode == 0) ? 15 : (i % 16);
  endtask

  // Starts at #1 after a rising edge; feeds start, 9 coefficients, npix pixels.
  task automatic feed0(input int relu, input int gap, input int inject, input int npix);
    repeat (3) begin
      pv0 = 1; pd0 = 4'd7;
      @(posedge clk); #1;
    end
    pv0 = 0; start0 = 1; relu0 = (relu != 0);
    @(posedge clk); #1;
    start0 = 0; relu0 = (relu == 0);
    for (int i = 0; i < 9; i++) begin
      cv0 = 1; cd0 = coef_tab[i][3:0];
      @(posedge clk); #1;
    end
    cv0 = 0;
    check("busy_loading0", int'(busy0), 1);
    for (int i = 0; i < npix; i++) begin
      for (int g = 0; g < 6 && $urandom_range(99) < gap; g++) begin
        pv0 = 0; start0 = 0; cv0 = 0;
        @(posedge clk); #1;
      end
      pv0 = 1; pd0 = pix_tab[i][3:0];
      start0 = (inject != 0) && (i == 10);
      cv0    = (inject != 0) && (i == 10);
      cd0    = 4'h8;
      @(posedge clk); #1;
    end
    pv0 = 0; start0 = 0; cv0 = 0;
  endtask

  task automatic run0(input int relu, input int gap, input int inject,
                      input int mode, input int cval, input string tag);
    int waited;
    for (int r = 2; r < 6; r++)
      for (int c = 2; c < 6; c++)
        q0.push_back((mode == 1) ? (((r - 1) * 6 + c - 1) % 16) : cval);
    ov_cnt0 = 0;
    feed0(relu, gap, inject, 36);
    waited = 0;
    for (int k = 1; k <= 10 && waited == 0; k++) begin
      @(negedge clk);
      if (done0) waited = k;
    end
    check({tag, "_done_latency"}, waited, 3);
    start0 = 1;
    @(posedge clk); #1;
    start0 = 0;
    check({tag, "_start_in_done_ignored"}, int'(busy0), 0);
    @(negedge clk);
    check({tag, "_result_count"}, ov_cnt0, 16);
    check({tag, "_queue_empty"}, q0.size(), 0);
  endtask

  initial begin
    int waited;
    @(negedge clk);
    check("reset_busy",      int'(busy0), 0);
    check("reset_out_valid", int'(ov0), 0);
    check("reset_out_data",  int'(od0), 0);
    check("reset_done",      int'(done0), 0);
    check("reset_busy1",     int'(busy1), 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    set_tabs(0, 0); run0(0, 0, 1, 0, 135, "ones");
    set_tabs(1, 1); run0(0, 0, 0, 1, 0, "identity");
    set_tabs(2, 0); run0(0, 0, 0, 0, -1080, "neg8");
    set_tabs(2, 0); run0(1, 0, 0, 0, 0, "neg8_relu");
    set_tabs(1, 1); run0(0, 30, 0, 1, 0, "identity_gaps");

    // Abort after 20 pixels: only the three results already out of the pipeline appear.
    set_tabs(0, 0);
    repeat (3) q0.push_back(135);
    feed0(0, 0, 0, 20);
    rst = 1;
    @(negedge clk);
    check("abort_busy",      int'(busy0), 0);
    check("abort_out_valid", int'(ov0), 0);
    check("abort_done",      int'(done0), 0);
    check("abort_queue",     q0.size(), 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // Signed 4x4 instance: all pixels -1, all coefficients 1.
    repeat (4) q1.push_back(-9);
    ov_cnt1 = 0;
    start1 = 1; relu1 = 0;
    @(posedge clk); #1;
    start1 = 0;
    for (int i = 0; i < 9; i++) begin
      cv1 = 1; cd1 = 4'd1;
      @(posedge clk); #1;
    end
    cv1 = 0;
    for (int i = 0; i < 16; i++) begin
      pv1 = 1; pd1 = 4'hF;
      @(posedge clk); #1;
    end
    pv1 = 0;
    waited = 0;
    for (int k = 1; k <= 10 && waited == 0; k++) begin
      @(negedge clk);
      if (done1) waited = k;
    end
    check("signed_done_latency", waited, 3);
    @(negedge clk);
    check("signed_result_count", ov_cnt1, 4);
    check("signed_queue_empty", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
